seq_addsub: RTL and testbench

- Parametrised, multi-cycle adder/subtractor.
- Each cycle it processes one CHUNK-bit slice of a WIDTH-bit operand pair, so a wide add costs only one CHUNK-bit ripple adder of area.
- Uses a valid/ready handshake on input and output, so it can sit beside the ALU as a shared arithmetic resource, for example for address or extended-precision arithmetic.
- Adds subtract mode, carry/overflow/zero flags and back-pressure, which the fixed-width combinational adders lack.

---
 rtl/seq_addsub_pkg.sv | 16 +
 rtl/seq_addsub_ripple.sv | 41 ++++
 rtl/seq_addsub.sv | 126 ++++++++++++
 tb/tb_seq_addsub.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_addsub_pkg.sv
// Shared definitions for the sequential adder/subtractor: FSM encoding and
// the counter-width helper.
package seq_addsub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // A single-chunk build still needs a one-bit counter to keep the ports legal.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_addsub_ripple.sv
// One-bit full adder cell and the N-bit ripple chain built from it; the
// sequential adder instantiates a single chain of CHUNK bits.
module fulladder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

module ripple_adder_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    logic [N:0] c;

    assign c[0] = Cin;
    assign Cout = c[N];

    for (genvar i = 0; i < N; i++) begin : g_bit
        fulladder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (S[i]),
            .cout (c[i+1])
        );
    end

endmodule

// File: rtl/seq_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit slice per cycle through a
// shared ripple adder, with valid/ready handshakes and registered flags.
module seq_addsub
    import seq_addsub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ofl,
    output logic             zero
);

    localparam int NCHUNK = (CHUNK >= 1) ? WIDTH / CHUNK : 1;
    localparam int CW     = cnt_width(NCHUNK);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    if (CHUNK < 1) begin : g_bad_chunk
        $error("seq_addsub: CHUNK must be at least 1");
    end else if (WIDTH % CHUNK != 0) begin : g_bad_split
        $error("seq_addsub: WIDTH must be a multiple of CHUNK");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CHUNK-1:0] a_sl;
    logic [CHUNK-1:0] b_sl;
    logic [CHUNK-1:0] s_sl;
    logic             c_out;

    always_comb begin
        a_sl = a_r[int'(cnt) * CHUNK +: CHUNK];
        b_sl = b_r[int'(cnt) * CHUNK +: CHUNK];
    end

    ripple_adder_n #(.N(CHUNK)) u_add (
        .A    (a_sl),
        .B    (b_sl),
        .Cin  (carry),
        .S    (s_sl),
        .Cout (c_out)
    );

    // Working result with the current slice merged in, so the final cycle can
    // publish the complete sum and its flags in one step.
    always_comb begin
        acc_next = acc;
        acc_next[int'(cnt) * CHUNK +: CHUNK] = s_sl;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            carry     <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ofl       <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        a_r      <= a;
                        b_r      <= sub ? ~b : b;
                        carry    <= sub | cin;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    acc   <= acc_next;
                    carry <= c_out;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= DONE;
                        out_valid <= 1'b1;
                        sum       <= acc_next;
                        cout      <= c_out;
                        zero      <= ~|acc_next;
                        ofl       <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (acc_next[WIDTH-1] != a_r[WIDTH-1]);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub.sv
// Self-checking bench for seq_addsub: directed vector table, corner-case
// sequences and randomized operations against an arithmetic reference model.
module tb_seq_addsub;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic        sub;
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    typedef struct {
        logic [15:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        cin = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        cout;
    logic        ofl;
    logic        zero;

    logic        in_valid_w = 1'b0;
    logic        in_ready_w;
    logic [15:0] a_w = '0;
    logic [15:0] b_w = '0;
    logic        cin_w = 1'b0;
    logic        sub_w = 1'b0;
    logic        out_valid_w;
    logic        out_ready_w = 1'b0;
    logic [15:0] sum_w;
    logic        cout_w;
    logic        ofl_w;
    logic        zero_w;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    seq_addsub #(.WIDTH(16), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ofl       (ofl),
        .zero      (zero)
    );

    seq_addsub #(.WIDTH(16), .CHUNK(16)) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_w),
        .in_ready  (in_ready_w),
        .a         (a_w),
        .b         (b_w),
        .cin       (cin_w),
        .sub       (sub_w),
        .out_valid (out_valid_w),
        .out_ready (out_ready_w),
        .sum       (sum_w),
        .cout      (cout_w),
        .ofl       (ofl_w),
        .zero      (zero_w)
    );

    // Reference: plain integer arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                   input logic mcin, input logic msub);
        res_t r;
        int   wide;
        int   sr;
        if (msub) begin
            wide = int'(ma) - int'(mb);
            sr   = int'($signed(ma)) - int'($signed(mb));
            r.co = (ma >= mb);
        end else begin
            wide = int'(ma) + int'(mb) + int'(mcin);
            sr   = int'($signed(ma)) + int'($signed(mb)) + int'(mcin);
            r.co = (wide > 65535);
        end
        r.s  = wide[15:0];
        r.ov = (sr > 32767) || (sr < -32768);
        r.z  = (r.s == 16'h0000);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic apply_stimulus(input logic [15:0] ta, input logic [15:0] tb,
                                  input logic tcin, input logic tsub);
        int waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("in_ready before accept", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 16'($urandom);
        b        = 16'($urandom);
        cin      = 1'($urandom);
        sub      = 1'($urandom);
    endtask

    task automatic wait_result(input string name, input int exp_lat);
        int lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, " latency"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_output(input string name, input res_t e);
        check({name, " out_valid"}, 32'(out_valid), 32'd1);
        check({name, " sum"}, 32'(sum), 32'(e.s));
        check({name, " cout"}, 32'(cout), 32'(e.co));
        check({name, " ofl"}, 32'(ofl), 32'(e.ov));
        check({name, " zero"}, 32'(zero), 32'(e.z));
    endtask

    task automatic finish_op(input string name);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({name, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        check({name, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        vec_t vecs[7];
        res_t e;
        res_t held;
        int   lat;

        vecs[0] = '{16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0};
        vecs[5] = '{16'h8000, 16'h8000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'h0000, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0};

        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset in_ready", 32'(in_ready), 32'd1);
        check("reset sum", 32'(sum), 32'd0);
        check("reset flags", {29'd0, cout, ofl, zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            apply_stimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            wait_result($sformatf("vec%0d", i), 4);
            e.s  = vecs[i].s;
            e.co = vecs[i].co;
            e.ov = vecs[i].ov;
            e.z  = vecs[i].z;
            check_output($sformatf("vec%0d", i), e);
            finish_op($sformatf("vec%0d", i));
        end

        // Back-pressure: result must hold while an extra in_valid pulse is ignored.
        apply_stimulus(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
        wait_result("bp", 4);
        held = model(16'hA5A5, 16'h0F0F, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                a        = 16'hFFFF;
                b        = 16'hFFFF;
                in_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            check($sformatf("bp hold%0d in_ready", i), 32'(in_ready), 32'd0);
            check_output($sformatf("bp hold%0d", i), held);
        end
        finish_op("bp");
        @(posedge clk);
        #1;
        check("bp ignored pulse", 32'(out_valid), 32'd0);

        // Asynchronous reset during the second RUN cycle.
        apply_stimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort out_valid", 32'(out_valid), 32'd0);
        check("abort sum", 32'(sum), 32'd0);
        check("abort in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("abort no output", 32'(out_valid), 32'd0);
        apply_stimulus(16'h0001, 16'h0001, 1'b0, 1'b0);
        wait_result("post-reset", 4);
        check_output("post-reset", model(16'h0001, 16'h0001, 1'b0, 1'b0));
        finish_op("post-reset");

        for (int i = 0; i < 30; i++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rc;
            logic        rs;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (i % 7 == 0) rb = ra;
            apply_stimulus(ra, rb, rc, rs);
            wait_result($sformatf("rnd%0d", i), 4);
            check_output($sformatf("rnd%0d", i), model(ra, rb, rc, rs));
            finish_op($sformatf("rnd%0d", i));
        end

        // Full-width instance: whole operation in a single RUN cycle.
        @(negedge clk);
        a_w        = 16'h0005;
        b_w        = 16'h0005;
        cin_w      = 1'b0;
        sub_w      = 1'b1;
        in_valid_w = 1'b1;
        check("wide in_ready", 32'(in_ready_w), 32'd1);
        @(posedge clk);
        #1;
        in_valid_w = 1'b0;
        lat = 0;
        while (!out_valid_w && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("wide latency", 32'(lat), 32'd1);
        check("wide sum", 32'(sum_w), 32'd0);
        check("wide zero", 32'(zero_w), 32'd1);
        check("wide cout", 32'(cout_w), 32'd1);
        check("wide ofl", 32'(ofl_w), 32'd0);
        out_ready_w = 1'b1;
        @(posedge clk);
        #1;
        out_ready_w = 1'b0;
        check("wide in_ready after handshake", 32'(in_ready_w), 32'd1);

        $display("[TB] %0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
